multimode_ff_bank: RTL and testbench

Parametrised successor to the single-bit D storage cell: a bank of WIDTH edge-triggered storage channels sharing one clock. Each cycle, a runtime mode selects D, T, SR or JK next-state logic for all channels. The block adds a change-detect pulse, a saturating change counter and sticky per-channel SR-conflict flags with a clear input. It is instantiated inside the tile top level, with inputs driven from ui_in/uio_in and results routed to uo_out/uio_out.

---
 rtl/multimode_ff_bank_if.sv | 33 +++
 rtl/multimode_ff_bank.sv | 100 ++++++++++
 tb/tb_multimode_ff_bank.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/multimode_ff_bank_if.sv
// ---------------------------------------------------------------------------
// multimode_ff_bank_if
// Bundles the control, data and status signals of multimode_ff_bank.
//   master : drives en, mode, a, b, err_clr; observes q, q_n, changed,
//            upd_cnt, err
//   slave  : the storage bank itself (the mirror image of master)
// Parameters WIDTH and CNT_W must match those of the attached bank.
// ---------------------------------------------------------------------------
interface multimode_ff_bank_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic             changed;
    logic [CNT_W-1:0] upd_cnt;
    logic [WIDTH-1:0] err;

    modport master (
        output en, mode, a, b, err_clr,
        input  q, q_n, changed, upd_cnt, err
    );

    modport slave (
        input  en, mode, a, b, err_clr,
        output q, q_n, changed, upd_cnt, err
    );
endinterface

// File: rtl/multimode_ff_bank.sv
// ---------------------------------------------------------------------------
// multimode_ff_bank
// A bank of WIDTH independent storage channels on one clock. A runtime mode
// selects D, T, SR or JK next-state behaviour for every channel at once.
// Also provides a change pulse, a saturating change counter and sticky
// per-channel SR forbidden-input flags.
//
// Ports
//   clk      : clock, all state on the rising edge
//   rst      : synchronous reset, active-high, overrides everything
//   bus      : slave side of multimode_ff_bank_if
//     en       update enable (0 = hold, no flags set, changed cleared)
//     mode     00=D 01=T 10=SR 11=JK
//     a, b     D/T/S/J and R/K inputs per channel
//     err_clr  clear all sticky err bits (a same-edge conflict still sets)
//     q, q_n   stored state and its inverse
//     changed  high for the cycle after any edge where q changed
//     upd_cnt  number of edges where q changed, saturating
//     err      sticky SR conflict flags
// All outputs come straight from registers (q_n is just ~q).
// ---------------------------------------------------------------------------
module multimode_ff_bank #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    multimode_ff_bank_if.slave  bus
);
    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_SR = 2'b10;
    localparam logic [1:0] MODE_JK = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic [WIDTH-1:0] conflict;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_moves;

    // Per-channel next-state; channels are fully independent.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic ai, bi, qi, nxt;
            assign ai = bus.a[gi];
            assign bi = bus.b[gi];
            assign qi = q_q[gi];

            always_comb begin
                nxt = qi;
                case (bus.mode)
                    MODE_D:  nxt = ai;
                    MODE_T:  nxt = qi ^ ai;
                    // a=b=1 is forbidden: hold and flag it.
                    MODE_SR: nxt = (ai & ~bi) | (qi & ~ai & ~bi) | (qi & ai & bi);
                    MODE_JK: nxt = (ai & ~qi) | (~bi & qi);
                    default: nxt = qi;
                endcase
            end

            assign q_d[gi]      = bus.en ? nxt : qi;
            assign conflict[gi] = bus.en & (bus.mode == MODE_SR) & ai & bi;
        end
    endgenerate

    assign q_moves = (q_d != q_q);

    always_comb begin
        changed_d = q_moves;
        cnt_d     = cnt_q;
        if (q_moves && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Clear first, then OR in new conflicts so a same-edge set wins.
        err_d = (bus.err_clr ? '0 : err_q) | conflict;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= RESET_VAL;
            err_q     <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            q_q       <= q_d;
            err_q     <= err_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.q_n     = ~q_q;
    assign bus.changed = changed_q;
    assign bus.upd_cnt = cnt_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed-vector bench for multimode_ff_bank (WIDTH=4, RESET_VAL=0, CNT_W=8).
module tb_multimode_ff_bank;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    multimode_ff_bank_if #(.WIDTH(4), .CNT_W(8)) bus ();

    multimode_ff_bank #(
        .WIDTH    (4),
        .RESET_VAL(4'b0000),
        .CNT_W    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [1:0] mode,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic clr);
        bus.en      = en;
        bus.mode    = mode;
        bus.a       = a;
        bus.b       = b;
        bus.err_clr = clr;
    endtask

    initial begin
        drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);

        // Reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_q",    32'(bus.q), 32'h0);
        chk("rst_qn",   32'(bus.q_n), 32'hF);
        chk("rst_chg",  32'(bus.changed), 0);
        chk("rst_cnt",  32'(bus.upd_cnt), 0);
        chk("rst_err",  32'(bus.err), 0);

        // D mode
        drive(1'b1, 2'b00, 4'b1010, 4'h0, 1'b0);
        step();
        chk("d_q",    32'(bus.q), 32'hA);
        chk("d_qn",   32'(bus.q_n), 32'h5);
        chk("d_chg",  32'(bus.changed), 1);
        chk("d_cnt",  32'(bus.upd_cnt), 1);
        step();
        chk("d_hold_chg", 32'(bus.changed), 0);
        chk("d_hold_cnt", 32'(bus.upd_cnt), 1);

        // T mode: 1010 -> 1001 -> 1010
        drive(1'b1, 2'b01, 4'b0011, 4'h0, 1'b0);
        step();
        chk("t1_q",   32'(bus.q), 32'h9);
        chk("t1_cnt", 32'(bus.upd_cnt), 2);
        step();
        chk("t2_q",   32'(bus.q), 32'hA);
        chk("t2_chg", 32'(bus.changed), 1);
        chk("t2_cnt", 32'(bus.upd_cnt), 3);

        // en=0 holds
        drive(1'b0, 2'b01, 4'b1111, 4'h0, 1'b0);
        step();
        chk("en0_q",   32'(bus.q), 32'hA);
        chk("en0_chg", 32'(bus.changed), 0);
        chk("en0_cnt", 32'(bus.upd_cnt), 3);

        // SR: from 1010, a=1100 b=0110 -> 1000, err=0100
        drive(1'b1, 2'b10, 4'b1100, 4'b0110, 1'b0);
        step();
        chk("sr_q",   32'(bus.q), 32'h8);
        chk("sr_err", 32'(bus.err), 32'h4);
        chk("sr_cnt", 32'(bus.upd_cnt), 4);

        // err_clr with new conflict on ch0: set dominates, ch2 clears
        drive(1'b1, 2'b10, 4'b0001, 4'b0001, 1'b1);
        step();
        chk("clr_err", 32'(bus.err), 32'h1);
        chk("clr_q",   32'(bus.q), 32'h8);
        chk("clr_chg", 32'(bus.changed), 0);

        // Load 0101, then JK a=1100 b=1010 -> 1101
        drive(1'b1, 2'b00, 4'b0101, 4'h0, 1'b0);
        step();
        chk("ld_q", 32'(bus.q), 32'h5);
        drive(1'b1, 2'b11, 4'b1100, 4'b1010, 1'b0);
        step();
        chk("jk_q",   32'(bus.q), 32'hD);
        chk("jk_err", 32'(bus.err), 32'h1);
        chk("jk_cnt", 32'(bus.upd_cnt), 6);

        // SR conflict with en=0 sets nothing
        drive(1'b0, 2'b10, 4'b1111, 4'b1111, 1'b0);
        step();
        chk("en0_sr_err", 32'(bus.err), 32'h1);
        chk("en0_sr_q",   32'(bus.q), 32'hD);

        // Clear plus conflict on ch1 -> err=0010
        drive(1'b1, 2'b10, 4'b0010, 4'b0010, 1'b1);
        step();
        chk("err_ch1", 32'(bus.err), 32'h2);

        // Build q=1111, upd_cnt=17 ahead of a mid-run reset
        drive(1'b1, 2'b01, 4'b0001, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        drive(1'b1, 2'b00, 4'b1111, 4'h0, 1'b0);
        step();
        chk("pre_q",   32'(bus.q), 32'hF);
        chk("pre_cnt", 32'(bus.upd_cnt), 17);
        chk("pre_err", 32'(bus.err), 32'h2);

        // Mid-run reset overrides en/mode/a
        drive(1'b1, 2'b00, 4'b1010, 4'h0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_q",   32'(bus.q), 32'h0);
        chk("mrst_err", 32'(bus.err), 32'h0);
        chk("mrst_cnt", 32'(bus.upd_cnt), 0);
        chk("mrst_chg", 32'(bus.changed), 0);

        // Saturation: toggle ch0 for 300 edges
        drive(1'b1, 2'b01, 4'b0001, 4'h0, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            step();
            chk("sat_chg", 32'(bus.changed), 1);
            if (i == 254) chk("sat_cnt254", 32'(bus.upd_cnt), 254);
            if (i == 255) chk("sat_cnt255", 32'(bus.upd_cnt), 255);
        end
        chk("sat_cnt_end", 32'(bus.upd_cnt), 255);
        chk("sat_q_end",   32'(bus.q), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
